mem_port_arbiter: RTL and testbench

//  Shares one pseudo-2-port memory (combinational read port, posedge write port) among
//  NUM_REQ requesters. It uses two independent round-robin arbiters, one for the read port
//  and one for the write port, each with bounded burst ownership. Sits between the PE/DMA

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares a pseudo-2-port memory among NUM_REQ clients using independent round-robin
// read and write arbiters with bounded burst ownership and a registered read-data stage.
module mem_port_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned HEIGHT    = 256,
   parameter int unsigned MAX_BURST = 4,
   localparam int unsigned AW       = $clog2(HEIGHT)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       rd_req,
   input  logic [NUM_REQ*AW-1:0]    rd_addr,
   output logic [NUM_REQ-1:0]       rd_gnt,
   output logic [NUM_REQ-1:0]       rd_rvalid,
   output logic [WIDTH-1:0]         rd_rdata,
   input  logic [NUM_REQ-1:0]       wr_req,
   input  logic [NUM_REQ*AW-1:0]    wr_addr,
   input  logic [NUM_REQ*WIDTH-1:0] wr_data,
   output logic [NUM_REQ-1:0]       wr_gnt,
   output logic [AW-1:0]            mem_read_addr,
   output logic                     mem_read_en,
   input  logic [WIDTH-1:0]         mem_qout,
   output logic [AW-1:0]            mem_write_addr,
   output logic [WIDTH-1:0]         mem_din,
   output logic                     mem_write_en
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, OWNED} state_t;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
      if (32'(v) == NUM_REQ - 1) return '0;
      return v + 1'b1;
   endfunction

   logic [NUM_REQ-1:0] req_a [2];
   logic [NUM_REQ-1:0] gnt_a [2];

   assign req_a[0] = rd_req;
   assign req_a[1] = wr_req;

   // Port 0 arbitrates reads, port 1 writes; the two never share state.
   for (genvar p = 0; p < 2; p++) begin : g_port
      state_t             state_q, state_d;
      logic [PW-1:0]      ptr_q, ptr_d, owner_q, owner_d, cur, win;
      logic [BW-1:0]      bcnt_q, bcnt_d;
      logic [NUM_REQ-1:0] req, gnt;
      logic               found, others;

      assign req = req_a[p];

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            bcnt_q  <= '0;
         end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
         end
      end

      always_comb begin
         state_d = state_q;
         ptr_d   = ptr_q;
         owner_d = owner_q;
         bcnt_d  = bcnt_q;
         gnt     = '0;
         found   = 1'b0;
         win     = '0;
         cur     = ptr_q;
         others  = |(req & ~(NUM_REQ'(1) << owner_q));
         if (state_q == OWNED && req[owner_q] &&
             (bcnt_q < BW'(MAX_BURST) || !others)) begin
            gnt[owner_q] = 1'b1;
            if (bcnt_q < BW'(MAX_BURST)) bcnt_d = bcnt_q + 1'b1;
         end else begin
            // Losing ownership moves priority past the owner before the search.
            if (state_q == OWNED) begin
               cur   = wrap_inc(owner_q);
               ptr_d = cur;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               if (!found && req[cur]) begin
                  found = 1'b1;
                  win   = cur;
               end
               cur = wrap_inc(cur);
            end
            if (found) begin
               gnt[win] = 1'b1;
               state_d  = OWNED;
               owner_d  = win;
               bcnt_d   = BW'(1);
               ptr_d    = wrap_inc(win);
            end else begin
               state_d = IDLE;
            end
         end
      end

      assign gnt_a[p] = gnt;
   end

   assign rd_gnt       = rst ? '0 : gnt_a[0];
   assign wr_gnt       = rst ? '0 : gnt_a[1];
   assign mem_read_en  = |rd_gnt;
   assign mem_write_en = |wr_gnt;

   always_comb begin
      mem_read_addr  = '0;
      mem_write_addr = '0;
      mem_din        = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (rd_gnt[i]) mem_read_addr = rd_addr[i*AW +: AW];
         if (wr_gnt[i]) begin
            mem_write_addr = wr_addr[i*AW +: AW];
            mem_din        = wr_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_rvalid <= '0;
         rd_rdata  <= '0;
      end else begin
         rd_rvalid <= rd_gnt;
         if (|rd_gnt) rd_rdata <= mem_qout;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural pseudo-2-port memory attached.
module tb_mem_port_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 16;
   localparam int unsigned H  = 256;
   localparam int unsigned AW = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   rd_req, rd_gnt, rd_rvalid, wr_req, wr_gnt;
   logic [N*AW-1:0] rd_addr, wr_addr;
   logic [N*W-1:0] wr_data;
   logic [W-1:0]   rd_rdata, mem_qout, mem_din;
   logic [AW-1:0]  mem_read_addr, mem_write_addr;
   logic           mem_read_en, mem_write_en;

   logic [W-1:0]   mem [H];
   logic           pre_en = 1'b0;
   logic [AW-1:0]  pre_addr = '0;
   logic [W-1:0]   pre_data = '0;
   int             wr_count = 0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.NUM_REQ(N), .WIDTH(W), .HEIGHT(H), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .mem_read_addr(mem_read_addr), .mem_read_en(mem_read_en), .mem_qout(mem_qout),
      .mem_write_addr(mem_write_addr), .mem_din(mem_din), .mem_write_en(mem_write_en)
   );

   assign mem_qout = mem[mem_read_addr];

   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (mem_write_en) begin
         mem[mem_write_addr] <= mem_din;
         wr_count <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rd_req = '0;
      wr_req = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
      pre_en = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_en = 1'b0;
   endtask

   initial begin
      int wc0;
      rst     = 1'b1;
      rd_req  = '1;
      wr_req  = '1;
      rd_addr = {N{8'h80}};
      wr_addr = {N{8'h80}};
      wr_data = '0;

      // Reset held two cycles with every client requesting
      for (int c = 0; c < 2; c++) begin
         tick();
         check($sformatf("rst_rd_gnt%0d", c), 32'(rd_gnt), 32'h0);
         check($sformatf("rst_wr_gnt%0d", c), 32'(wr_gnt), 32'h0);
         check($sformatf("rst_ens%0d", c), {30'b0, mem_read_en, mem_write_en}, 32'h0);
         check($sformatf("rst_rvalid%0d", c), 32'(rd_rvalid), 32'h0);
         check($sformatf("rst_rdata%0d", c), 32'(rd_rdata), 32'h0);
      end
      rst = 1'b0;
      #1;
      check("post_rst_rd_gnt", 32'(rd_gnt), 32'h1);
      check("post_rst_wr_gnt", 32'(wr_gnt), 32'h1);
      tick();
      rd_req = '0;
      wr_req = '0;
      check("post_rst_rvalid", 32'(rd_rvalid), 32'h1);

      // Read latency
      do_reset();
      preload(8'd5, 16'hBEEF);
      rd_addr[2*AW +: AW] = 8'd5;
      rd_req = 4'b0100;
      #1;
      check("lat_gnt", 32'(rd_gnt), 32'h4);
      check("lat_en", 32'(mem_read_en), 32'h1);
      check("lat_addr", 32'(mem_read_addr), 32'h5);
      tick();
      rd_req = '0;
      check("lat_rvalid", 32'(rd_rvalid), 32'h4);
      check("lat_rdata", 32'(rd_rdata), 32'hBEEF);
      tick();
      check("lat_rvalid_drop", 32'(rd_rvalid), 32'h0);
      check("lat_rdata_hold", 32'(rd_rdata), 32'hBEEF);

      // Round robin with bursts of four
      do_reset();
      rd_req = '1;
      for (int c = 0; c < 16; c++) begin
         #1;
         check($sformatf("rr_gnt%0d", c), 32'(rd_gnt), 32'(1) << (c / 4));
         tick();
      end
      rd_req = '0;

      // Lone writer keeps the port past the burst limit
      do_reset();
      wc0 = wr_count;
      wr_req = 4'b0010;
      for (int c = 0; c < 10; c++) begin
         wr_addr[1*AW +: AW] = 8'(20 + c);
         wr_data[1*W +: W]   = 16'(16'h1000 + c);
         #1;
         check($sformatf("lone_gnt%0d", c), 32'(wr_gnt), 32'h2);
         check($sformatf("lone_waddr%0d", c), 32'(mem_write_addr), 32'(20 + c));
         tick();
      end
      wr_req = '0;
      check("lone_wr_count", 32'(wr_count - wc0), 32'd10);
      check("lone_mem_last", 32'(mem[29]), 32'h1009);

      // Same-address read and write in one cycle
      do_reset();
      preload(8'd7, 16'h0001);
      rd_addr[0 +: AW]    = 8'd7;
      wr_addr[3*AW +: AW] = 8'd7;
      wr_data[3*W +: W]   = 16'h00AA;
      rd_req = 4'b0001;
      wr_req = 4'b1000;
      #1;
      check("haz_rd_gnt", 32'(rd_gnt), 32'h1);
      check("haz_wr_gnt", 32'(wr_gnt), 32'h8);
      tick();
      wr_req = '0;
      check("haz_old_data", 32'(rd_rdata), 32'h0001);
      tick();
      rd_req = '0;
      check("haz_new_data", 32'(rd_rdata), 32'h00AA);

      // Reset in the middle of a burst
      do_reset();
      rd_addr[0 +: AW]    = 8'd5;
      rd_addr[2*AW +: AW] = 8'd5;
      rd_req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("mid_gnt%0d", c), 32'(rd_gnt), 32'h4);
         tick();
      end
      rst = 1'b1;
      rd_req = '1;
      #1;
      check("mid_rst_gnt", 32'(rd_gnt), 32'h0);
      check("mid_rst_en", 32'(mem_read_en), 32'h0);
      tick();
      check("mid_rst_rvalid", 32'(rd_rvalid), 32'h0);
      check("mid_rst_rdata", 32'(rd_rdata), 32'h0);
      rst = 1'b0;
      #1;
      check("mid_ptr0_gnt", 32'(rd_gnt), 32'h1);
      tick();
      rd_req = '0;
      check("mid_ptr0_rvalid", 32'(rd_rvalid), 32'h1);
      check("mid_ptr0_rdata", 32'(rd_rdata), 32'hBEEF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
